// File: rtl/iob_split_tmo_if.sv
// IOb splitter bus bundle: one master request/response pair plus the
// packed slave request/response vectors.
interface iob_split_tmo_if #(
   parameter int N_SLAVES = 2,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32
);
   localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
   localparam int RESP_W = DATA_W + 1;

   logic [REQ_W-1:0]           m_req;
   logic [RESP_W-1:0]          m_resp;
   logic [N_SLAVES*REQ_W-1:0]  s_req;
   logic [N_SLAVES*RESP_W-1:0] s_resp;

   modport master (
      output m_req,
      input  m_resp,
      input  s_req,
      output s_resp
   );

   modport slave (
      input  m_req,
      output m_resp,
      output s_req,
      input  s_resp
   );
endinterface

// File: rtl/iob_split_tmo.sv
// IOb address splitter with unmapped-select completion and a
// per-transaction timeout watchdog that frees a hung master.
module iob_split_tmo #(
   parameter int N_SLAVES = 2,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int SEL_MSB  = 31,
   parameter int SEL_W    = 2,
   parameter int TIMEOUT  = 256,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
   input  logic       clk,
   input  logic       rst,
   iob_split_tmo_if.slave bus,
   input  logic       err_clr,
   output logic       err_flag,
   output logic [1:0] err_code,
   output logic [15:0] err_cnt
);
   localparam int STRB_W = DATA_W / 8;
   localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
   localparam int RESP_W = DATA_W + 1;
   localparam int PLD_W  = REQ_W - 1;
   localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit TMO_EN = (TIMEOUT != 0);
   localparam logic [TMO_W-1:0] TMO_LAST =
      TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   if (N_SLAVES > (1 << SEL_W) || N_SLAVES < 1) begin : g_cfg_chk
      $error("iob_split_tmo: N_SLAVES must be in 1..2**SEL_W");
   end

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      ERR
   } state_t;

   state_t             state;
   logic [SEL_W-1:0]   sel_q;
   logic [TMO_W-1:0]   tmo_cnt;

   logic               m_valid;
   logic [PLD_W-1:0]   m_pld;
   logic [ADDR_W-1:0]  m_addr;
   logic [SEL_W-1:0]   sel;
   logic               mapped;
   logic               s_rdy;
   logic [DATA_W-1:0]  s_rdata;
   logic               busy;
   logic               tmo_last;
   logic               tmo_hit;
   logic               err_evt;
   logic [RESP_W-1:0]  m_resp;
   logic [N_SLAVES*REQ_W-1:0] s_req;
   logic               flag_nxt;
   logic [1:0]         code_nxt;
   logic [15:0]        cnt_nxt;

   assign m_valid = bus.m_req[REQ_W-1];
   assign m_pld   = bus.m_req[PLD_W-1:0];
   assign m_addr  = m_pld[PLD_W-1 -: ADDR_W];
   assign sel     = m_addr[SEL_MSB -: SEL_W];
   assign mapped  = int'(sel) < N_SLAVES;

   always_comb begin
      s_rdy   = 1'b0;
      s_rdata = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (sel_q == SEL_W'(k)) begin
            s_rdy   = bus.s_resp[k*RESP_W];
            s_rdata = bus.s_resp[k*RESP_W+1 +: DATA_W];
         end
      end
   end

   assign busy     = (state == BUSY);
   assign tmo_last = TMO_EN && (tmo_cnt == TMO_LAST);
   assign tmo_hit  = busy && tmo_last && !s_rdy;
   assign err_evt  = (state == ERR) || tmo_hit;

   // The watchdog cycle drops the slave valid without looking at the
   // slave's ready, so a combinational slave cannot form a loop.
   always_comb begin
      s_req = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         s_req[k*REQ_W +: REQ_W] =
            {busy && !tmo_last && (sel_q == SEL_W'(k)), m_pld};
      end
   end

   always_comb begin
      m_resp = '0;
      unique case (state)
         IDLE: m_resp = '0;
         BUSY: begin
            if (s_rdy)         m_resp = {s_rdata, 1'b1};
            else if (tmo_last) m_resp = {ERR_DATA, 1'b1};
            else               m_resp = {s_rdata, 1'b0};
         end
         ERR:     m_resp = {ERR_DATA, 1'b1};
         default: m_resp = '0;
      endcase
   end

   assign bus.m_resp = m_resp;
   assign bus.s_req  = s_req;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sel_q   <= '0;
         tmo_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (m_valid) begin
                  sel_q   <= sel;
                  tmo_cnt <= '0;
                  state   <= mapped ? BUSY : ERR;
               end
            end
            BUSY: begin
               if (s_rdy || tmo_last) state <= IDLE;
               else tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            ERR:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Clear wins over a same-cycle error for flag and count only.
   always_comb begin
      flag_nxt = err_flag;
      code_nxt = err_code;
      cnt_nxt  = err_cnt;
      if (err_evt) begin
         flag_nxt = 1'b1;
         code_nxt = (state == ERR) ? 2'd1 : 2'd2;
         if (err_cnt != 16'hFFFF) cnt_nxt = err_cnt + 16'd1;
      end
      if (err_clr) begin
         flag_nxt = 1'b0;
         cnt_nxt  = 16'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_flag <= 1'b0;
         err_code <= 2'd0;
         err_cnt  <= 16'd0;
      end else begin
         err_flag <= flag_nxt;
         err_code <= code_nxt;
         err_cnt  <= cnt_nxt;
      end
   end
endmodule

// File: tb/tb_iob_split_tmo.sv
// Randomized bench for iob_split_tmo: a transaction-level plan predicts
// every output cycle by cycle, plus directed literal scenarios.
module tb_iob_split_tmo;
   localparam int NS     = 2;
   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int TMO    = 8;
   localparam int REQ_W  = 1 + AW + DW + DW / 8;
   localparam int RESP_W = DW + 1;
   localparam int PLD_W  = REQ_W - 1;
   localparam int NEVER  = 255;
   localparam logic [31:0] ERRD = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        err_clr = 1'b0;
   logic        err_flag;
   logic [1:0]  err_code;
   logic [15:0] err_cnt;

   iob_split_tmo_if #(.N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

   iob_split_tmo #(
      .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .SEL_MSB(31),
      .SEL_W(2), .TIMEOUT(TMO), .ERR_DATA(32'hDEADBEEF)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .err_clr(err_clr),
      .err_flag(err_flag), .err_code(err_code), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   // Plan of the transaction in flight
   bit          p_act = 1'b0;
   bit          p_map, p_to, p_err;
   int          p_t, p_tc, p_sel;
   logic [1:0]  p_code;
   logic [31:0] p_rdata;

   // Error bookkeeping model
   bit          e_flag = 1'b0;
   logic [1:0]  e_code = 2'd0;
   int          e_cnt  = 0;

   int          s_dly[NS];
   logic [31:0] s_dat[NS];
   int          s_vc[NS];
   int          late_cyc = -1;
   bit          chk_en = 1'b0;
   bit          clr_rand = 1'b0;
   int          last_rdy_cyc = -1;
   logic [31:0] last_rdata = '0;

   function automatic bit in_window(input int k);
      return p_act && p_map && k == p_sel && cyc >= p_t + 1 && cyc <= p_tc;
   endfunction

   // Slaves: answer after s_dly valid cycles; spurious readies elsewhere
   always @(posedge clk) begin
      #2;
      for (int k = 0; k < NS; k++) begin
         logic v, rdy;
         logic [31:0] d;
         v = bus.s_req[k*REQ_W + REQ_W - 1];
         rdy = 1'b0;
         if (v === 1'b1) begin
            rdy = (s_vc[k] == s_dly[k]);
            s_vc[k]++;
         end else begin
            s_vc[k] = 0;
            if (!in_window(k)) rdy = ($urandom_range(0, 3) == 0);
         end
         if (k == 0 && cyc == late_cyc) rdy = 1'b1;
         d = rdy ? s_dat[k] : $urandom;
         bus.s_resp[k*RESP_W +: RESP_W] = {d, rdy};
      end
   end

   // Single compare process against the plan
   always @(negedge clk) begin
      if (chk_en) begin
         bit busy, fin, ev;
         busy = p_act && p_map && cyc >= p_t + 1 && cyc <= p_tc;
         fin  = p_act && cyc == p_tc;
         for (int k = 0; k < NS; k++) begin
            ev = busy && k == p_sel && !(p_to && cyc == p_tc);
            chk($sformatf("s%0d_valid", k),
                bus.s_req[k*REQ_W + REQ_W - 1], ev);
            if (busy)
               chk($sformatf("s%0d_pld", k), bus.s_req[k*REQ_W +: PLD_W],
                   bus.m_req[PLD_W-1:0]);
         end
         chk("m_ready", bus.m_resp[0], fin);
         if (fin) chk("m_rdata", bus.m_resp[RESP_W-1:1], p_rdata);
         else if (!busy) chk("m_resp_idle", bus.m_resp, 0);
         chk("err_flag", err_flag, e_flag);
         chk("err_code", err_code, e_code);
         chk("err_cnt", err_cnt, e_cnt);
         if (bus.m_resp[0] === 1'b1) begin
            last_rdy_cyc = cyc;
            last_rdata   = bus.m_resp[RESP_W-1:1];
         end
         if (rst) begin
            e_flag = 1'b0;
            e_code = 2'd0;
            e_cnt  = 0;
            p_act  = 1'b0;
         end else begin
            if (fin && p_err) begin
               e_flag = 1'b1;
               e_code = p_code;
               if (e_cnt < 65535) e_cnt++;
            end
            if (err_clr) begin
               e_flag = 1'b0;
               e_cnt  = 0;
            end
         end
      end
      if (cyc > 60000) begin
         $display("FAIL watchdog cyc=%0d", cyc);
         $fatal(1, "bench watchdog expired");
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      err_clr = clr_rand ? ($urandom_range(0, 15) == 0) : 1'b0;
   endtask

   task automatic start(input logic [31:0] addr, input bit we,
                        input logic [31:0] wd, input int dly,
                        input logic [31:0] sd);
      int sel;
      logic [3:0] ws;
      sel   = int'(addr[31:30]);
      p_t   = cyc;
      p_sel = sel;
      p_map = sel < NS;
      if (!p_map) begin
         p_tc = cyc + 1; p_to = 1'b0; p_err = 1'b1;
         p_code = 2'd1; p_rdata = ERRD;
      end else if (dly <= TMO - 2) begin
         p_tc = cyc + 1 + dly; p_to = 1'b0; p_err = 1'b0;
         p_code = 2'd0; p_rdata = sd;
         s_dly[sel] = dly; s_dat[sel] = sd;
      end else begin
         p_tc = cyc + TMO; p_to = 1'b1; p_err = 1'b1;
         p_code = 2'd2; p_rdata = ERRD;
         s_dly[sel] = NEVER; s_dat[sel] = sd;
      end
      p_act = 1'b1;
      ws = we ? 4'($urandom_range(1, 15)) : 4'h0;
      bus.m_req = {1'b1, addr, wd, ws};
   endtask

   task automatic finish_req();
      while (cyc <= p_tc) tick();
      bus.m_req = {1'b0, 32'($urandom), 32'($urandom), 4'h0};
   endtask

   task automatic xfer(input logic [31:0] addr, input bit we,
                       input logic [31:0] wd, input int dly,
                       input logic [31:0] sd);
      start(addr, we, wd, dly, sd);
      finish_req();
   endtask

   initial begin
      int t;
      bus.m_req  = '0;
      bus.s_resp = '0;
      for (int k = 0; k < NS; k++) begin
         s_dly[k] = NEVER; s_dat[k] = '0; s_vc[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      tick(); tick();

      // Mapped read to slave1, answer after 3 cycles
      t = cyc;
      xfer(32'h4000_0010, 1'b0, 32'h0, 3, 32'h1234_5678);
      chk("rd_model_lat", p_tc - t, 4);
      chk("rd_lat", last_rdy_cyc - t, 4);
      chk("rd_data", last_rdata, 32'h1234_5678);
      chk("rd_errcnt", err_cnt, 0);

      // Unmapped write
      t = cyc;
      xfer(32'hC000_0000, 1'b1, 32'hA5A5_A5A5, 0, 32'h0);
      chk("um_lat", last_rdy_cyc - t, 1);
      chk("um_data", last_rdata, 32'hDEADBEEF);
      chk("um_code", err_code, 2'd1);
      chk("um_flag", err_flag, 1'b1);
      chk("um_cnt", err_cnt, 16'd1);

      // Timeout on slave0, late ready ignored
      t = cyc;
      late_cyc = t + 12;
      xfer(32'h0000_0100, 1'b0, 32'h0, NEVER, 32'h0);
      chk("to_lat", last_rdy_cyc - t, 8);
      chk("to_data", last_rdata, 32'hDEADBEEF);
      chk("to_code", err_code, 2'd2);
      while (cyc <= t + 13) tick();
      chk("to_late_ign", last_rdy_cyc - t, 8);
      chk("to_cnt", err_cnt, 16'd2);

      // Back-to-back to slave0 then slave1
      t = cyc;
      xfer(32'h0000_0020, 1'b0, 32'h0, 0, 32'h1111_0000);
      chk("b2b0_lat", last_rdy_cyc - t, 1);
      chk("b2b0_data", last_rdata, 32'h1111_0000);
      xfer(32'h4000_0020, 1'b0, 32'h0, 0, 32'h2222_0001);
      chk("b2b1_lat", last_rdy_cyc - t, 3);
      chk("b2b1_data", last_rdata, 32'h2222_0001);

      // Saturation then clear colliding with an error
      tick();
      force dut.err_cnt = 16'hFFFE;
      e_cnt = 65534;
      tick();
      release dut.err_cnt;
      repeat (3) xfer(32'hC000_0004, 1'b1, 32'h5, 0, 32'h0);
      chk("sat_cnt", err_cnt, 16'hFFFF);
      start(32'h8000_0000, 1'b0, 32'h0, 0, 32'h0);
      tick();
      err_clr = 1'b1;
      tick();
      finish_req();
      chk("clr_flag", err_flag, 1'b0);
      chk("clr_cnt", err_cnt, 16'd0);
      chk("clr_code", err_code, 2'd1);

      // Randomized traffic
      clr_rand = 1'b1;
      repeat (300) begin
         logic [31:0] a;
         int d;
         repeat ($urandom_range(0, 2)) tick();
         a = {2'($urandom_range(0, 3)), 30'($urandom)};
         d = ($urandom_range(0, 9) < 7) ? $urandom_range(0, TMO - 2) : NEVER;
         xfer(a, 1'($urandom), $urandom, d, $urandom);
      end
      clr_rand = 1'b0;

      // Make error state nonzero, then reset in BUSY cycle 2
      xfer(32'hC000_0000, 1'b0, 32'h0, 0, 32'h0);
      t = cyc;
      start(32'h4000_0000, 1'b0, 32'h0, NEVER, 32'h0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.m_req = '0;
      repeat (12) tick();
      chk("rst_noready", last_rdy_cyc > t, 1'b0);
      chk("rst_flag", err_flag, 1'b0);
      chk("rst_code", err_code, 2'd0);
      chk("rst_cnt", err_cnt, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
